// File: rtl/ad9653_spi_responder.sv
// Device-side model of the AD9653 3-wire SPI configuration port: oversamples CSB/SCLK/SDIO on clk,
// decodes the 16-bit instruction and reads/writes a byte register file with a host readback port.
module ad9653_spi_responder #(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] CHIP_ID = 8'h73,
  parameter int         SYNC_N  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csb,
  input  logic              sclk,
  input  logic              sdio_in,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              busy,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_rdata
);
  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [12:0] ADDR_TOP = 13'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;

  logic [SYNC_N-1:0] sclk_sync_q, csb_sync_q, sdio_sync_q;
  logic              sclk_prev_q;
  logic              sclk_s, csb_s, sdio_s, sclk_rise, sclk_fall;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  wmode_q, wmode_d;
  logic [12:0] addr_q, addr_d;
  logic [14:0] instr_q, instr_d;
  logic [6:0]  wshift_q, wshift_d;
  logic [7:0]  rshift_q, rshift_d;
  logic        sdo_q, sdo_d, sdo_oe_q, sdo_oe_d, busy_q, busy_d;
  logic        wr_stb_q, wr_stb_d, sr_pend_q, sr_pend_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d, host_rdata_q, host_rdata_d;

  logic [15:0] instr_full;
  logic [7:0]  byte_full;
  logic [12:0] addr_next;
  logic        byte_last;
  logic        file_we;
  logic [ADDR_W-1:0] file_waddr;
  logic [7:0]  file_wdata;
  logic [7:0]  file_rd [DEPTH];

  function automatic logic in_range(input logic [12:0] a);
    return (a >> ADDR_W) == 13'd0;
  endfunction

  function automatic logic [12:0] dec_addr(input logic [12:0] a);
    return (a == 13'd0) ? ADDR_TOP : a - 13'd1;
  endfunction

  assign sclk_s    = sclk_sync_q[SYNC_N-1];
  assign csb_s     = csb_sync_q[SYNC_N-1];
  assign sdio_s    = sdio_sync_q[SYNC_N-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      csb_sync_q  <= '1;
      sdio_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_N-2:0], sclk};
      csb_sync_q  <= {csb_sync_q[SYNC_N-2:0], csb};
      sdio_sync_q <= {sdio_sync_q[SYNC_N-2:0], sdio_in};
      sclk_prev_q <= sclk_s;
    end
  end

  // Register file: per-byte cells so a soft reset can reload every default in one clock.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_file
    localparam logic [7:0] DEF = (gi == 1) ? CHIP_ID : 8'h00;
    logic [7:0] cell_q, cell_d;
    always_comb begin
      cell_d = cell_q;
      if (sr_pend_q)
        cell_d = DEF;
      else if (file_we && file_waddr == ADDR_W'(gi))
        cell_d = file_wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cell_q <= DEF;
      else        cell_q <= cell_d;
    end
    assign file_rd[gi] = cell_q;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    wmode_d      = wmode_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    wshift_d     = wshift_q;
    rshift_d     = rshift_q;
    sdo_d        = sdo_q;
    sdo_oe_d     = sdo_oe_q;
    busy_d       = ~csb_s;
    wr_stb_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sr_pend_d    = 1'b0;
    host_rdata_d = file_rd[host_addr];
    file_we      = 1'b0;
    file_waddr   = addr_q[ADDR_W-1:0];
    file_wdata   = 8'h00;
    instr_full   = {instr_q, sdio_s};
    byte_full    = {wshift_q, sdio_s};
    addr_next    = dec_addr(addr_q);
    byte_last    = (wmode_q != 2'b11) && (byte_cnt_q == wmode_q);

    // A synced csb high overrides any sclk edge seen in the same sample.
    if (csb_s) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sdo_d      = 1'b0;
      sdo_oe_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = INSTR;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
        INSTR: if (sclk_rise) begin
          instr_d   = instr_full[14:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            wmode_d = instr_full[14:13];
            addr_d  = instr_full[12:0];
            if (instr_full[15]) begin
              state_d  = RDATA;
              rshift_d = in_range(instr_full[12:0]) ? file_rd[instr_full[ADDR_W-1:0]] : 8'h00;
            end else begin
              state_d = WDATA;
            end
          end
        end
        WDATA: if (sclk_rise) begin
          wshift_d  = byte_full[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (in_range(addr_q)) begin
              wr_stb_d   = 1'b1;
              wr_addr_d  = addr_q[ADDR_W-1:0];
              wr_data_d  = byte_full;
              file_we    = (addr_q != 13'd1);
              // Soft-reset bit is self-clearing in the stored copy of register 0.
              file_wdata = (addr_q == 13'd0) ? (byte_full & 8'hDF) : byte_full;
              sr_pend_d  = (addr_q == 13'd0) && byte_full[5];
            end
            addr_d     = addr_next;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_last) state_d = DONE;
          end
        end
        RDATA: begin
          if (sclk_fall) begin
            sdo_d    = rshift_q[7];
            sdo_oe_d = 1'b1;
            rshift_d = {rshift_q[6:0], 1'b0};
          end else if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = '0;
              addr_d     = addr_next;
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_last) state_d = DONE;
              else rshift_d = in_range(addr_next) ? file_rd[addr_next[ADDR_W-1:0]] : 8'h00;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      wmode_q      <= '0;
      addr_q       <= '0;
      instr_q      <= '0;
      wshift_q     <= '0;
      rshift_q     <= '0;
      sdo_q        <= 1'b0;
      sdo_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      sr_pend_q    <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      wmode_q      <= wmode_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      wshift_q     <= wshift_d;
      rshift_q     <= rshift_d;
      sdo_q        <= sdo_d;
      sdo_oe_q     <= sdo_oe_d;
      busy_q       <= busy_d;
      wr_stb_q     <= wr_stb_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      sr_pend_q    <= sr_pend_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign sdo        = sdo_q;
  assign sdo_oe     = sdo_oe_q;
  assign busy       = busy_q;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_ad9653_spi_responder.sv
// Scoreboard bench: SPI master tasks push expected writes/read bytes from a register-map model;
// monitors pop and compare as wr_stb pulses and sdo bits appear.
module tb_ad9653_spi_responder;
  logic       clk = 1'b0, rst_n = 1'b0, csb = 1'b1, sclk = 1'b0, sdio_in = 1'b0;
  logic       sdo, sdo_oe, busy, wr_stb;
  logic [7:0] wr_addr, wr_data, host_rdata;
  logic [7:0] host_addr = 8'h00;

  int checks = 0, failures = 0;
  logic [7:0]  mem [256];
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [15:0] e_wr;
  logic [7:0]  e_rd, rd_byte = 8'h00;
  bit          rd_active = 1'b0;
  int          rd_bits = 0;

  always #5 clk = ~clk;

  ad9653_spi_responder #(.ADDR_W(8), .CHIP_ID(8'h73), .SYNC_N(2)) dut (
    .clk(clk), .rst_n(rst_n), .csb(csb), .sclk(sclk), .sdio_in(sdio_in),
    .sdo(sdo), .sdo_oe(sdo_oe), .busy(busy), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .host_addr(host_addr), .host_rdata(host_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'h73;
  endtask

  function automatic logic [12:0] next_addr(input logic [12:0] a);
    return (a == 13'd0) ? 13'd255 : a - 13'd1;
  endfunction

  // Write monitor: every wr_stb pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected actual=%0h/%0h required=none", wr_addr, wr_data);
      end else begin
        e_wr = exp_wr_q.pop_front();
        chk("wr_commit", {16'h0, wr_addr, wr_data}, {16'h0, e_wr});
      end
    end
  end

  // Read monitor: master samples sdo on its own sclk rise while the device drives.
  initial forever begin
    @(posedge sclk);
    if (rd_active && sdo_oe) begin
      rd_byte = {rd_byte[6:0], sdo};
      rd_bits++;
      if (rd_bits == 8) begin
        rd_bits = 0;
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual=%0h required=none", rd_byte);
        end else begin
          e_rd = exp_rd_q.pop_front();
          chk("rd_byte", {24'h0, rd_byte}, {24'h0, e_rd});
        end
      end
    end else begin
      rd_bits = 0;
    end
  end

  task automatic spi_bit(input logic b);
    sdio_in = b;
    #60 sclk = 1'b1;
    #60 sclk = 1'b0;
  endtask

  task automatic send_instr(input logic [15:0] ins, input bit is_rd);
    for (int i = 15; i >= 1; i--) spi_bit(ins[i]);
    sdio_in = ins[0];
    #60 sclk = 1'b1;
    #50;
    if (is_rd) chk("oe_before_fall", {31'h0, sdo_oe}, 32'h0);
    #10 sclk = 1'b0;
    if (is_rd) begin
      #50;
      chk("oe_after_fall", {31'h0, sdo_oe}, 32'h1);
    end
  endtask

  task automatic open_txn();
    csb = 1'b0;
    #100;
    chk("busy_open", {31'h0, busy}, 32'h1);
  endtask

  task automatic close_txn();
    #100 csb = 1'b1;
    #200;
    chk("oe_closed", {31'h0, sdo_oe}, 32'h0);
    chk("busy_closed", {31'h0, busy}, 32'h0);
  endtask

  task automatic spi_write(input logic [1:0] w, input logic [12:0] a, input logic [31:0] data, input int n);
    logic [12:0] cur;
    logic [7:0]  d;
    int          lim;
    cur = a;
    lim = (w == 2'b11) ? n : ((n < int'(w) + 1) ? n : int'(w) + 1);
    for (int i = 0; i < lim; i++) begin
      d = data[31-8*i -: 8];
      if (cur[12:8] == 5'd0) begin
        exp_wr_q.push_back({cur[7:0], d});
        if (cur != 13'd1) mem[cur[7:0]] = d;
        if (cur == 13'd0) begin
          mem[0] = d & 8'hDF;
          if (d[5]) model_reset();
        end
      end
      cur = next_addr(cur);
    end
    open_txn();
    send_instr({1'b0, w, a}, 1'b0);
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) spi_bit(data[31-8*i-(7-b)]);
    close_txn();
  endtask

  task automatic spi_read(input logic [1:0] w, input logic [12:0] a, input int n);
    logic [12:0] cur;
    cur = a;
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back((cur[12:8] == 5'd0) ? mem[cur[7:0]] : 8'h00);
      cur = next_addr(cur);
    end
    rd_active = 1'b1;
    open_txn();
    send_instr({1'b1, w, a}, 1'b1);
    for (int i = 0; i < n * 8; i++) spi_bit(1'b0);
    #60;
    rd_active = 1'b0;
    chk("oe_held", {31'h0, sdo_oe}, 32'h1);
    close_txn();
  endtask

  task automatic spi_abort(input logic [12:0] a, input int nbits);
    open_txn();
    send_instr({3'b000, a}, 1'b0);
    for (int i = 0; i < nbits; i++) spi_bit(1'($urandom_range(0, 1)));
    close_txn();
  endtask

  task automatic host_check(input logic [7:0] a);
    host_addr = a;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("host_rdata[%0h]", a), {24'h0, host_rdata}, {24'h0, mem[a]});
  endtask

  int          op, n;
  logic [1:0]  w;
  logic [12:0] a;

  initial begin
    model_reset();
    #20;
    chk("rst_sdo", {31'h0, sdo}, 32'h0);
    chk("rst_sdo_oe", {31'h0, sdo_oe}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
    chk("rst_wr", {16'h0, wr_addr, wr_data}, 32'h0);
    chk("rst_host_rdata", {24'h0, host_rdata}, 32'h0);
    #23 rst_n = 1'b1;
    #100;
    host_check(8'h01);

    spi_write(2'b00, 13'h014, 32'h01000000, 1);
    host_check(8'h14);
    spi_read(2'b00, 13'h001, 1);
    spi_write(2'b00, 13'h001, 32'hAA000000, 1);
    host_check(8'h01);
    spi_write(2'b10, 13'h016, 32'hA1B2C3D4, 4);
    for (int i = 8'h13; i <= 8'h17; i++) host_check(8'(i));
    spi_write(2'b00, 13'h0FF, 32'h5E000000, 1);
    spi_read(2'b11, 13'h001, 3);
    spi_abort(13'h014, 5);
    host_check(8'h14);
    spi_write(2'b00, 13'h014, 32'h01000000, 1);
    spi_write(2'b00, 13'h000, 32'h20000000, 1);
    host_check(8'h14);
    host_check(8'h00);
    host_check(8'h01);
    spi_write(2'b00, 13'h1200, 32'h5A000000, 1);
    host_check(8'h00);

    // Reset asserted in the middle of a read.
    spi_write(2'b00, 13'h014, 32'h55000000, 1);
    open_txn();
    send_instr({1'b1, 2'b00, 13'h014}, 1'b1);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    #20 rst_n = 1'b0;
    #1;
    chk("mid_rst_sdo_oe", {31'h0, sdo_oe}, 32'h0);
    chk("mid_rst_sdo", {31'h0, sdo}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_wr", {15'h0, wr_stb, wr_addr, wr_data}, 32'h0);
    chk("mid_rst_host", {24'h0, host_rdata}, 32'h0);
    model_reset();
    #29 csb = 1'b1;
    #50 rst_n = 1'b1;
    #100;
    host_check(8'h14);
    host_check(8'h01);

    for (int t = 0; t < 30; t++) begin
      op = $urandom_range(0, 9);
      w  = 2'($urandom_range(0, 3));
      a  = 13'($urandom_range(0, 255));
      if (op <= 4) begin
        spi_write(w, a, $urandom, $urandom_range(1, 4));
      end else if (op <= 6) begin
        n = (w == 2'b11) ? $urandom_range(1, 4) : int'(w) + 1;
        spi_read(w, a, n);
      end else if (op == 7) begin
        spi_write(2'b00, {5'($urandom_range(1, 31)), a[7:0]}, $urandom, 1);
      end else if (op == 8) begin
        spi_read(2'b00, {5'($urandom_range(1, 31)), a[7:0]}, 1);
      end else begin
        spi_abort(a, $urandom_range(1, 7));
      end
    end

    for (int i = 0; i < 256; i++) host_check(8'(i));
    #100;
    chk("wr_queue_empty", exp_wr_q.size(), 32'h0);
    chk("rd_queue_empty", exp_rd_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
